// File: rtl/control_decoder_if.sv
// Bus between a select source and control_decoder.
//   addr   : select index, ADDR_W bits (master -> slave)
//   enable : decode enable, active-high (master -> slave)
//   out    : one-hot decoded select, OUT_W bits (slave -> master)
interface control_decoder_if #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned OUT_W  = 2**ADDR_W
);
   logic [ADDR_W-1:0] addr;
   logic              enable;
   logic [OUT_W-1:0]  out;

   modport master (output addr, output enable, input  out);
   modport slave  (input  addr, input  enable, output out);
endinterface

// File: rtl/control_decoder.sv
// One-hot select decoder.
// Decodes bus.addr into a one-hot bus.out when bus.enable is high; an
// address at or beyond OUT_W, or enable low, yields all zeros.
// Ports:
//   clk    : clock, rising edge (used only in the registered build)
//   rst_n  : asynchronous active-low reset (used only in the registered build)
//   bus    : control_decoder_if.slave carrying addr, enable and out
// Build option:
//   CONTROL_DECODER_REG_OUT_EN defined   -> out registered, 1-cycle latency,
//                                          cleared asynchronously by rst_n
//   CONTROL_DECODER_REG_OUT_EN undefined -> out purely combinational,
//                                          clk/rst_n functionally unused
module control_decoder #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned OUT_W  = 2**ADDR_W
) (
   input  logic           clk,
   input  logic           rst_n,
   control_decoder_if.slave bus
);

   logic [OUT_W-1:0] decode_c;

   // Bitwise AND (not an if) so X on enable or addr reaches out unmasked.
   always_comb begin
      decode_c = '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         decode_c[i] = bus.enable & (bus.addr == ADDR_W'(i));
      end
   end

`ifdef CONTROL_DECODER_REG_OUT_EN
   logic [OUT_W-1:0] out_d;
   logic [OUT_W-1:0] out_q;

   always_comb begin
      out_d = decode_c;
   end

   // Output register: the only state in the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.out = out_q;
`else
   // clk and rst_n stay on the port list for a build-independent footprint.
   logic unused_c;
   assign unused_c = clk ^ rst_n;

   assign bus.out = decode_c;
`endif

endmodule

// File: tb/tb_control_decoder.sv
module tb_control_decoder;

   logic clk;
   logic rst_n;

   control_decoder_if #(.ADDR_W(3), .OUT_W(8)) bus8 ();
   control_decoder_if #(.ADDR_W(3), .OUT_W(6)) bus6 ();

   control_decoder #(.ADDR_W(3), .OUT_W(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   control_decoder #(.ADDR_W(3), .OUT_W(6)) u_dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus6.slave)
   );

   typedef struct {
      logic [7:0] e8;
      logic [5:0] e6;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;
   logic [7:0] last8;
   logic [5:0] last6;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: one-hot of addr when enabled and addr fits the width.
   function automatic logic [7:0] ref_dec(input int unsigned a, input logic en,
                                          input int unsigned w);
      logic [7:0] r;
      r = 8'h00;
      if (en && a < w) r = 8'(1 << a);
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_onehot(input string name, input logic [7:0] act);
      checks++;
      if ($countones(act) > 1) begin
         failures++;
         $display("FAIL %s more than one bit set actual=%h at %0t", name, act, $time);
      end
   endtask

   // Apply inputs on the falling edge; queue what both DUTs must show after the next rising edge.
   task automatic drive(input int unsigned a, input logic en);
      exp_t e;
      @(negedge clk);
      bus8.addr   = 3'(a);
      bus8.enable = en;
      bus6.addr   = 3'(a);
      bus6.enable = en;
      e.e8 = ref_dec(a, en, 8);
      e.e6 = 6'(ref_dec(a, en, 6));
      sb_q.push_back(e);
      #1;
`ifdef CONTROL_DECODER_REG_OUT_EN
      check("hold8", bus8.out, last8);
      check("hold6", {2'b00, bus6.out}, {2'b00, last6});
`else
      check("comb8", bus8.out, e.e8);
      check("comb6", {2'b00, bus6.out}, {2'b00, e.e6});
`endif
      last8 = e.e8;
      last6 = e.e6;
   endtask

   // Monitor: every rising edge, pop the pending expectation and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         check_onehot("onehot8", bus8.out);
         check_onehot("onehot6", {2'b00, bus6.out});
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb8", bus8.out, e.e8);
            check("sb6", {2'b00, bus6.out}, {2'b00, e.e6});
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < 10) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d expected=0 pending", sb_q.size());
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      bus8.addr   = 3'd0;
      bus8.enable = 1'b0;
      bus6.addr   = 3'd0;
      bus6.enable = 1'b0;
      last8       = 8'h00;
      last6       = 6'h00;
      #1;
      check("reset8", bus8.out, 8'h00);
      check("reset6", {2'b00, bus6.out}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) drive(i, 1'b1);
      for (int i = 0; i < 8; i++) drive(i, 1'b0);
      drive(5, 1'b1);
      drive(5, 1'b0);
      drive(5, 1'b1);
      for (int i = 0; i < 40; i++) drive($urandom_range(0, 7), 1'($urandom_range(0, 1)));

      // Asynchronous reset mid-cycle with addr=3, enable=1.
      drive(3, 1'b1);
      drain();
      @(posedge clk);
      #2;
      check("pre_rst8", bus8.out, 8'h08);
      rst_n = 1'b0;
      #1;
`ifdef CONTROL_DECODER_REG_OUT_EN
      check("async_rst8", bus8.out, 8'h00);
      check("async_rst6", {2'b00, bus6.out}, 8'h00);
`else
      check("rst_noeffect8", bus8.out, 8'h08);
      check("rst_noeffect6", {2'b00, bus6.out}, 8'h08);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
`ifdef CONTROL_DECODER_REG_OUT_EN
      check("rel_hold8", bus8.out, 8'h00);
`else
      check("rel_hold8", bus8.out, 8'h08);
`endif
      @(posedge clk);
      #1;
      check("rel_load8", bus8.out, 8'h08);
      check("rel_load6", {2'b00, bus6.out}, 8'h08);
      last8 = 8'h08;
      last6 = 6'h08;

      for (int i = 7; i >= 0; i--) drive(i, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/control_decoder.md
CONTROL_DECODER -- requirements
Module: control_decoder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 3, meaning the select width in bits.
REQ-002 The module SHALL have parameter OUT_W, default 2**ADDR_W (8), meaning the one-hot output width; legal values are 1 to 2**ADDR_W.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The module SHALL have port addr, input, ADDR_W bits, the select index.
REQ-006 The module SHALL have port enable, input, 1 bit, the decode enable; it is active-high.
REQ-007 The module SHALL have port out, output, OUT_W bits, the one-hot decoded select.

Function
REQ-008 When enable=1 and addr<OUT_W, the decoded value SHALL have only bit out[addr] set to 1; all other bits SHALL be 0.
REQ-009 When enable=0, the decoded value SHALL be all zeros regardless of addr.
REQ-010 When enable=1 and addr>=OUT_W, the decoded value SHALL be all zeros; this case only occurs when OUT_W<2**ADDR_W.
REQ-011 The decoded value SHALL never have more than one bit set.
REQ-012 X or Z on enable or addr SHALL NOT be masked; simulation MAY propagate X onto out.
REQ-013 Output timing SHALL depend on the configuration macro (REQ-017/REQ-018).
REQ-014 No other state SHALL exist beyond the optional output register.

Reset
REQ-015 When rst_n=0, out SHALL be 8'h00 (all OUT_W bits zero) immediately, without waiting for clk, in the registered build.
REQ-016 On rst_n deassertion, the first rising clk edge SHALL load the decode of the current addr and enable; out SHALL hold zeros until that edge.

Configuration
REQ-017 With macro CONTROL_DECODER_REG_OUT_EN defined, out SHALL be registered.
  - Latency: out SHALL reflect the addr and enable sampled at the previous rising clk edge, a latency of 1 cycle.
  - Reset: REQ-015 and REQ-016 SHALL apply.
REQ-018 With CONTROL_DECODER_REG_OUT_EN undefined, out SHALL be purely combinational from addr and enable with zero latency.
  - clk and rst_n SHALL remain ports but SHALL be functionally unused.
  - Reset SHALL have no effect on out.
REQ-019 The decode truth table SHALL be identical in both builds; only timing and reset behaviour differ.

Verification
REQ-020 The bench SHALL cover the exhaustive sweep: enable=1, addr 0..7 -> out = 8'h01, 02, 04, 08, 10, 20, 40, 80.
  - Registered build: each value appears one cycle after its addr is applied.
  - Combinational build: each value appears after settling.
REQ-021 The bench SHALL cover the disable case: enable=0, addr swept 0..7 -> out=8'h00 for every addr.
REQ-022 The bench SHALL cover enable toggling: addr=5, enable 1->0->1 -> out 8'h20 -> 8'h00 -> 8'h20.
  - Registered build: each change lands one clk edge later.
REQ-023 The bench SHALL cover asynchronous reset in the registered build: addr=3, enable=1, out=8'h08, then rst_n=0 mid-cycle.
  - out SHALL be 8'h00 before the next clk edge.
  - After release, out SHALL be 8'h08 on the first rising edge.
REQ-024 The bench SHALL cover a reduced width: OUT_W=6, enable=1.
  - addr=5 -> out=6'b100000.
  - addr=6 -> out=6'b000000.
  - addr=7 -> out=6'b000000.
REQ-025 The bench SHALL check on every sampled cycle of all scenarios that $countones(out) <= 1.
